// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: each accepted beat is steered by in_sel into
// one of two 1-deep output holding registers, each with its own delivered-beat counter.
module stream_demux_1to2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic             full0_q, full0_d;
    logic             full1_q, full1_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic sel_full;
    logic sel_ready;
    logic wr0, wr1;
    logic rd0, rd1;

    // Only the selected port can stall the producer; a full port that is draining
    // this edge still has room, which is what gives 1 beat/cycle per port.
    always_comb begin
        sel_full  = in_sel ? full1_q : full0_q;
        sel_ready = in_sel ? out1_ready : out0_ready;
        in_ready  = (sel_full == EMPTY) | sel_ready;
    end

    always_comb begin
        wr0 = in_valid & in_ready & ~in_sel;
        wr1 = in_valid & in_ready & in_sel;
        rd0 = (full0_q == FULL) & out0_ready;
        rd1 = (full1_q == FULL) & out1_ready;
    end

    // A write on the same edge as a read wins, so the slot stays full with the new beat.
    always_comb begin
        full0_d = full0_q;
        buf0_d  = buf0_q;
        cnt0_d  = cnt0_q;
        if (rd0) begin
            full0_d = EMPTY;
            cnt0_d  = cnt0_q + CNT_W'(1);
        end
        if (wr0) begin
            full0_d = FULL;
            buf0_d  = in_data;
        end
    end

    always_comb begin
        full1_d = full1_q;
        buf1_d  = buf1_q;
        cnt1_d  = cnt1_q;
        if (rd1) begin
            full1_d = EMPTY;
            cnt1_d  = cnt1_q + CNT_W'(1);
        end
        if (wr1) begin
            full1_d = FULL;
            buf1_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full0_q <= EMPTY;
            full1_q <= EMPTY;
            buf0_q  <= '0;
            buf1_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            full0_q <= full0_d;
            full1_q <= full1_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_comb begin
        out0_valid = full0_q;
        out0_data  = buf0_q;
        out1_valid = full1_q;
        out1_data  = buf1_q;
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: stimulus pushes expected beats into per-port
// queues, and a negedge monitor pops and compares on every output handshake.
module tb_stream_demux_1to2;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    logic       stall0_seen, stall1_seen;
    logic [7:0] held0, held1;

    stream_demux_1to2 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offer one beat and hold it until accepted; the expected beat is queued on acceptance.
    task automatic applyStimulus(input logic [7:0] data, input logic sel, output int waits);
        logic accepted;
        accepted = 1'b0;
        waits    = 0;
        in_data  = data;
        in_sel   = sel;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (sel) exp_q1.push_back(data);
                else     exp_q0.push_back(data);
            end
            @(posedge clk);
            #1;
            if (accepted) break;
            waits++;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic doReset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q0.delete();
        exp_q1.delete();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor plus hold-stability check for stalled outputs.
    always @(negedge clk) begin
        if (reset) begin
            stall0_seen <= 1'b0;
            stall1_seen <= 1'b0;
        end else begin
            if (stall0_seen) begin
                checkOutput("stable0_valid", int'(out0_valid), 1);
                checkOutput("stable0_data", int'(out0_data), int'(held0));
            end
            if (stall1_seen) begin
                checkOutput("stable1_valid", int'(out1_valid), 1);
                checkOutput("stable1_data", int'(out1_data), int'(held1));
            end
            if (out0_valid && out0_ready) begin
                if (exp_q0.size() == 0) checkOutput("unexpected_out0", int'(out0_data), -1);
                else checkOutput("out0_data", int'(out0_data), int'(exp_q0.pop_front()));
            end
            if (out1_valid && out1_ready) begin
                if (exp_q1.size() == 0) checkOutput("unexpected_out1", int'(out1_data), -1);
                else checkOutput("out1_data", int'(out1_data), int'(exp_q1.pop_front()));
            end
            stall0_seen <= out0_valid & ~out0_ready;
            stall1_seen <= out1_valid & ~out1_ready;
            held0       <= out0_data;
            held1       <= out1_data;
        end
    end

    initial begin
        int w;
        stall0_seen = 1'b0;
        stall1_seen = 1'b0;
        held0 = 8'h00;
        held1 = 8'h00;
        reset = 1'b1;
        in_valid = 1'b0;
        in_sel = 1'b0;
        in_data = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1;
        checkOutput("rst_out0_valid", int'(out0_valid), 0);
        checkOutput("rst_out1_valid", int'(out1_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_cnt0", int'(cnt0), 0);

        // Single beat to out0, visible one cycle after acceptance.
        doReset();
        out0_ready = 1'b1;
        applyStimulus(8'h3C, 1'b0, w);
        checkOutput("t1_wait", w, 0);
        checkOutput("t1_out0_valid", int'(out0_valid), 1);
        checkOutput("t1_out0_data", int'(out0_data), 8'h3C);
        checkOutput("t1_out1_valid", int'(out1_valid), 0);
        idle(1);
        checkOutput("t1_cnt0", int'(cnt0), 1);
        checkOutput("t1_out0_drained", int'(out0_valid), 0);

        // Back-to-back stream on out1.
        doReset();
        out1_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, w);
            checkOutput("t2_wait", w, 0);
            checkOutput("t2_out1_data", int'(out1_data), i);
        end
        idle(1);
        checkOutput("t2_cnt1", int'(cnt1), 5);
        checkOutput("t2_cnt0", int'(cnt0), 0);

        // Backpressure on out0 must not block out1.
        doReset();
        out1_ready = 1'b1;
        applyStimulus(8'hAA, 1'b0, w);
        checkOutput("t3_wait_aa", w, 0);
        in_data = 8'hBB;
        in_sel = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t3_in_ready_blocked", int'(in_ready), 0);
            checkOutput("t3_out0_held", int'(out0_data), 8'hAA);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        applyStimulus(8'hCC, 1'b1, w);
        checkOutput("t3_wait_cc", w, 0);
        checkOutput("t3_out1_data", int'(out1_data), 8'hCC);
        out0_ready = 1'b1;
        applyStimulus(8'hBB, 1'b0, w);
        checkOutput("t3_wait_bb", w, 0);
        idle(2);
        checkOutput("t3_cnt0", int'(cnt0), 2);
        checkOutput("t3_cnt1", int'(cnt1), 1);

        // Simultaneous drain and write on out0.
        doReset();
        applyStimulus(8'h11, 1'b0, w);
        out0_ready = 1'b1;
        applyStimulus(8'h22, 1'b0, w);
        checkOutput("t4_wait", w, 0);
        checkOutput("t4_out0_valid", int'(out0_valid), 1);
        checkOutput("t4_out0_data", int'(out0_data), 8'h22);
        checkOutput("t4_cnt0", int'(cnt0), 1);
        idle(1);
        checkOutput("t4_cnt0_final", int'(cnt0), 2);

        // cnt1 wrap after 256 deliveries.
        doReset();
        out1_ready = 1'b1;
        for (int i = 0; i < 255; i++) applyStimulus(8'(i), 1'b1, w);
        idle(1);
        checkOutput("t5_cnt1_255", int'(cnt1), 255);
        applyStimulus(8'hF0, 1'b1, w);
        idle(1);
        checkOutput("t5_cnt1_wrap", int'(cnt1), 0);
        checkOutput("t5_cnt0", int'(cnt0), 0);

        // Async reset while both outputs are full and stalled.
        doReset();
        out0_ready = 1'b1;
        applyStimulus(8'h77, 1'b0, w);
        idle(1);
        checkOutput("t6_cnt0_pre", int'(cnt0), 1);
        out0_ready = 1'b0;
        applyStimulus(8'h5A, 1'b0, w);
        applyStimulus(8'hA5, 1'b1, w);
        checkOutput("t6_full0", int'(out0_valid), 1);
        checkOutput("t6_full1", int'(out1_valid), 1);
        in_data = 8'h99;
        in_sel = 1'b0;
        in_valid = 1'b1;
        idle(1);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("t6_rst_valid0", int'(out0_valid), 0);
        checkOutput("t6_rst_valid1", int'(out1_valid), 0);
        checkOutput("t6_rst_data0", int'(out0_data), 0);
        checkOutput("t6_rst_data1", int'(out1_data), 0);
        checkOutput("t6_rst_cnt0", int'(cnt0), 0);
        checkOutput("t6_rst_cnt1", int'(cnt1), 0);
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("t6_post_in_ready", int'(in_ready), 1);
        idle(1);
        checkOutput("t6_post_valid0", int'(out0_valid), 0);

        checkOutput("q0_empty", exp_q0.size(), 0);
        checkOutput("q1_empty", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Registered 1-to-2 stream demultiplexer. It is the receive-side counterpart of the 2:1 data mux.
- Each accepted input beat is routed by its per-beat select to one of two output streams.
- Each output has a 1-deep holding register with valid/ready flow control and a wrapping beat counter.
- Sits between a single producer and two independent consumers.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 8, width of each per-output delivered-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input beat data.
- in_sel  input  1  destination of current beat: 0 routes to out0, 1 routes to out1. Meaningful only while in_valid=1.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the input beat this cycle.
- out0_data  output  WIDTH  output 0 data.
- out0_valid  output  1  output 0 holds a beat.
- out0_ready  input  1  consumer 0 accepts.
- out1_data  output  WIDTH  output 1 data.
- out1_valid  output  1  output 1 holds a beat.
- out1_ready  input  1  consumer 1 accepts.
- cnt0  output  CNT_W  beats delivered on out0 (handshakes), wraps.
- cnt1  output  CNT_W  beats delivered on out1, wraps.

Behaviour:
- Reset (async assert, takes effect immediately): full0=full1=0, out0_data=out1_data=0, cnt0=cnt1=0. Consequently out*_valid=0 and in_ready=1.
- Reset is released synchronously to clk by the surrounding logic.
- Per output k, state is full_k (EMPTY/FULL) and data register buf_k. Then out_k_valid=full_k and out_k_data=buf_k.
- Readiness:
  - in_ready = ~full[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready of the selected port only.
  - The unselected port never stalls the input.
- Input handshake: in_valid & in_ready at an edge writes buf[in_sel] <= in_data and sets full[in_sel] <= 1.
- Latency: a beat accepted at edge N is visible on out_k at edge N (out_k_valid=1 after that edge, i.e. in cycle N+1). No combinational path from in_data to out_data.
- Output handshake on port k: out_k_valid & out_k_ready at an edge.
  - Clears full_k, unless a write to k occurs on the same edge.
  - Increments cnt_k by 1 modulo 2^CNT_W (all-ones -> 0).
- Simultaneous read and write on the same port: the old beat is delivered and counted. The new beat is loaded and full_k stays 1, giving full throughput of 1 beat/cycle per port.
- Write to one port while the other port drains: the two are independent and both take effect on the same edge.
- Stability: while out_k_valid=1 and out_k_ready=0, out_k_data and out_k_valid hold constant.
- Backpressure: selected port full and not draining gives in_ready=0. The input beat is not consumed and no state changes for that port.
- in_valid=0: no write regardless of in_sel or in_ready.
- Order is preserved per output. No ordering guarantee across outputs.
- No data is duplicated or dropped. Total accepted = delivered0 + delivered1 + full0 + full1.
- Reset mid-operation discards any held beats immediately. Counters return to 0.

Test Plan:
- Reset, then in_data=0x3C, in_sel=0, in_valid=1 for one cycle, out0_ready=1 -> out0_valid=1 with out0_data=0x3C exactly one cycle later, out1_valid stays 0, cnt0=1 after the output handshake.
- Stream 0x01..0x05 to out1 with out1_ready held 1 and in_valid held 1 -> in_ready constantly 1. out1 shows 0x01..0x05 on consecutive cycles, each one cycle after acceptance. Final cnt1=5, cnt0=0.
- out0_ready=0, send 0xAA to out0 then 0xBB to out0 -> 0xAA is held and in_ready=0 while in_sel=0. With in_sel=1 and 0xCC, in_ready=1 and 0xCC appears on out1. Raising out0_ready delivers 0xAA then 0xBB in order.
- Simultaneous drain and write on out0 (full with 0x11, out0_ready=1, in 0x22 with sel=0) -> next cycle out0_valid=1 with 0x22, cnt0 increments by 1.
- Preload cnt1 to 255 via 255 delivered beats, deliver one more -> cnt1=0, cnt0 unaffected.
- Assert reset while both outputs are full and mid-stall -> out0_valid=out1_valid=0, data 0, cnt0=cnt1=0 immediately, without waiting for a clock edge. After release, in_ready=1.
